poly_mac_ctrl: RTL and testbench

POLY_MAC_CTRL -- requirements
Module: poly_mac_ctrl

---
 rtl/mult_pkg.sv | 17 +
 rtl/multiple_gen.sv | 19 +
 rtl/poly_mac_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_poly_mac_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and FSM encoding for the negacyclic polynomial MAC controller
package mult_pkg;

    localparam int COEF_W  = 13;
    localparam int DIGIT_W = 4;
    localparam int MAG_MAX = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_S  = 3'd1,
        S_LATCH = 3'd2,
        RUN     = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/multiple_gen.sv
// rtl/multiple_gen.sv - shift/add generation of 2a..5a, wrapping mod 2^13
module multiple_gen
    import mult_pkg::*;
(
    input  logic [COEF_W-1:0] a,
    output logic [COEF_W-1:0] a_mul_2,
    output logic [COEF_W-1:0] a_mul_3,
    output logic [COEF_W-1:0] a_mul_4,
    output logic [COEF_W-1:0] a_mul_5
);

    always_comb begin
        a_mul_2 = a << 1;
        a_mul_3 = (a << 1) + a;
        a_mul_4 = a << 2;
        a_mul_5 = (a << 2) + a;
    end

endmodule

// File: rtl/poly_mac_ctrl.sv
// rtl/poly_mac_ctrl.sv - schoolbook a*s in Z_(2^13)[x]/(x^N+1) driving an external MAC stage
module poly_mac_ctrl
    import mult_pkg::*;
#(
    parameter int N  = 256,
    parameter int AW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       a_addr,
    input  logic [COEF_W-1:0]   a_rdata,
    output logic [AW-1:0]       s_addr,
    input  logic [DIGIT_W-1:0]  s_rdata,
    output logic [COEF_W-1:0]   mac_ri,
    output logic [COEF_W-1:0]   mac_a,
    output logic [DIGIT_W-1:0]  mac_s,
    output logic [COEF_W-1:0]   mac_a_mul_2,
    output logic [COEF_W-1:0]   mac_a_mul_3,
    output logic [COEF_W-1:0]   mac_a_mul_4,
    output logic [COEF_W-1:0]   mac_a_mul_5,
    input  logic [COEF_W-1:0]   mac_result,
    input  logic [AW-1:0]       res_addr,
    output logic [COEF_W-1:0]   res_data
);

    state_t              state_q, state_d;
    logic [AW-1:0]       i_q, i_d, j_q, j_d;
    logic [DIGIT_W-1:0]  s_reg_q, s_reg_d;
    logic                drain_q, drain_d;

    // Issue stage: k and wrap flag travel alongside the pending a read.
    logic                iss_vld_q, iss_vld_d, iss_neg_q, iss_neg_d;
    logic [AW-1:0]       iss_k_q, iss_k_d;

    logic                st1_vld_q, st1_vld_d, st1_neg_q, st1_neg_d;
    logic [AW-1:0]       st1_k_q, st1_k_d;
    logic [COEF_W-1:0]   st1_a_q, st1_a_d, st1_m2_q, st1_m2_d, st1_m3_q, st1_m3_d;
    logic [COEF_W-1:0]   st1_m4_q, st1_m4_d, st1_m5_q, st1_m5_d;
    logic [COEF_W-1:0]   gen_m2, gen_m3, gen_m4, gen_m5;

    logic [COEF_W-1:0]   acc_q [N];
    logic [COEF_W-1:0]   acc_d [N];

    multiple_gen u_multiple_gen (
        .a       (a_rdata),
        .a_mul_2 (gen_m2),
        .a_mul_3 (gen_m3),
        .a_mul_4 (gen_m4),
        .a_mul_5 (gen_m5)
    );

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        s_reg_d   = s_reg_q;
        drain_d   = drain_q;
        iss_vld_d = 1'b0;
        iss_neg_d = iss_neg_q;
        iss_k_d   = iss_k_q;
        st1_vld_d = iss_vld_q;
        st1_neg_d = st1_neg_q;
        st1_k_d   = st1_k_q;
        st1_a_d   = st1_a_q;
        st1_m2_d  = st1_m2_q;
        st1_m3_d  = st1_m3_q;
        st1_m4_d  = st1_m4_q;
        st1_m5_d  = st1_m5_q;
        acc_d     = acc_q;

        if (iss_vld_q) begin
            st1_neg_d = iss_neg_q;
            st1_k_d   = iss_k_q;
            st1_a_d   = a_rdata;
            st1_m2_d  = gen_m2;
            st1_m3_d  = gen_m3;
            st1_m4_d  = gen_m4;
            st1_m5_d  = gen_m5;
        end

        if (st1_vld_q) begin
            acc_d[st1_k_q] = mac_result;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_S;
                    i_d     = '0;
                    j_d     = '0;
                    for (int k = 0; k < N; k++) begin
                        acc_d[k] = '0;
                    end
                end
            end
            LOAD_S: state_d = S_LATCH;
            S_LATCH: begin
                s_reg_d = s_rdata;
                i_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                iss_vld_d            = 1'b1;
                {iss_neg_d, iss_k_d} = {1'b0, i_q} + {1'b0, j_q};
                if (i_q == AW'(N - 1)) begin
                    i_d     = '0;
                    drain_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    i_d = i_q + AW'(1);
                end
            end
            DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) begin
                    if (j_q == AW'(N - 1)) begin
                        j_d     = '0;
                        state_d = DONE;
                    end else begin
                        j_d     = j_q + AW'(1);
                        state_d = LOAD_S;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            s_reg_q   <= '0;
            drain_q   <= 1'b0;
            iss_vld_q <= 1'b0;
            iss_neg_q <= 1'b0;
            iss_k_q   <= '0;
            st1_vld_q <= 1'b0;
            st1_neg_q <= 1'b0;
            st1_k_q   <= '0;
            st1_a_q   <= '0;
            st1_m2_q  <= '0;
            st1_m3_q  <= '0;
            st1_m4_q  <= '0;
            st1_m5_q  <= '0;
            acc_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            s_reg_q   <= s_reg_d;
            drain_q   <= drain_d;
            iss_vld_q <= iss_vld_d;
            iss_neg_q <= iss_neg_d;
            iss_k_q   <= iss_k_d;
            st1_vld_q <= st1_vld_d;
            st1_neg_q <= st1_neg_d;
            st1_k_q   <= st1_k_d;
            st1_a_q   <= st1_a_d;
            st1_m2_q  <= st1_m2_d;
            st1_m3_q  <= st1_m3_d;
            st1_m4_q  <= st1_m4_d;
            st1_m5_q  <= st1_m5_d;
            acc_q     <= acc_d;
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        a_addr   = i_q;
        s_addr   = j_q;
        res_data = acc_q[res_addr];
        mac_ri      = '0;
        mac_a       = '0;
        mac_s       = '0;
        mac_a_mul_2 = '0;
        mac_a_mul_3 = '0;
        mac_a_mul_4 = '0;
        mac_a_mul_5 = '0;
        if (st1_vld_q) begin
            mac_ri      = acc_q[st1_k_q];
            mac_a       = st1_a_q;
            mac_s       = {s_reg_q[3] ^ st1_neg_q, s_reg_q[2:0]};
            mac_a_mul_2 = st1_m2_q;
            mac_a_mul_3 = st1_m3_q;
            mac_a_mul_4 = st1_m4_q;
            mac_a_mul_5 = st1_m5_q;
        end
    end

endmodule

// File: tb/tb_poly_mac_ctrl.sv
// tb/tb_poly_mac_ctrl.sv - directed bench for poly_mac_ctrl with N=4, modelling memories and MAC stage
module tb_poly_mac_ctrl;

    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst, start, busy, done;
    logic [AW-1:0] a_addr, s_addr, res_addr;
    logic [12:0]   a_rdata, mac_ri, mac_a, mac_result, res_data;
    logic [12:0]   mac_a_mul_2, mac_a_mul_3, mac_a_mul_4, mac_a_mul_5;
    logic [3:0]    s_rdata, mac_s;
    logic [12:0]   a_mem [N];
    logic [3:0]    s_mem [N];
    logic [12:0]   prod;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    poly_mac_ctrl #(.N(N), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .a_addr(a_addr), .a_rdata(a_rdata), .s_addr(s_addr), .s_rdata(s_rdata),
        .mac_ri(mac_ri), .mac_a(mac_a), .mac_s(mac_s),
        .mac_a_mul_2(mac_a_mul_2), .mac_a_mul_3(mac_a_mul_3),
        .mac_a_mul_4(mac_a_mul_4), .mac_a_mul_5(mac_a_mul_5),
        .mac_result(mac_result), .res_addr(res_addr), .res_data(res_data)
    );

    always @(posedge clk) begin
        a_rdata <= a_mem[a_addr];
        s_rdata <= s_mem[s_addr];
    end

    always_comb begin
        case (mac_s[2:0])
            3'd0:    prod = 13'd0;
            3'd1:    prod = mac_a;
            3'd2:    prod = mac_a_mul_2;
            3'd3:    prod = mac_a_mul_3;
            3'd4:    prod = mac_a_mul_4;
            3'd5:    prod = mac_a_mul_5;
            default: prod = 13'(mac_a * 13'(mac_s[2:0]));
        endcase
        mac_result = mac_s[3] ? (mac_ri - prod) : (mac_ri + prod);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [12:0] a0, a1, a2, a3, input logic [3:0] s0, s1, s2, s3);
        a_mem[0] = a0; a_mem[1] = a1; a_mem[2] = a2; a_mem[3] = a3;
        s_mem[0] = s0; s_mem[1] = s1; s_mem[2] = s2; s_mem[3] = s3;
    endtask

    task automatic check_res(input string tag, input int e0, e1, e2, e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int k = 0; k < N; k++) begin
            res_addr = AW'(k);
            #1;
            chk($sformatf("%s_c%0d", tag, k), int'(res_data), e[k]);
        end
    endtask

    task automatic do_op(input string tag, input int e0, e1, e2, e3);
        int cyc;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 33);
        chk({tag, "_busy_at_done"}, int'(busy), 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(done), 0);
        chk({tag, "_idle"}, int'(busy), 0);
        check_res(tag, e0, e1, e2, e3);
    endtask

    initial begin
        int dn, first, cyc;
        rst = 1'b1; start = 1'b0; res_addr = '0;
        load(13'd0, 13'd0, 13'd0, 13'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_a_addr", int'(a_addr), 0);
        chk("rst_s_addr", int'(s_addr), 0);
        chk("rst_mac_ri", int'(mac_ri), 0);
        chk("rst_mac_a", int'(mac_a), 0);
        chk("rst_mac_s", int'(mac_s), 0);
        check_res("rst", 0, 0, 0, 0);

        load(13'd1, 13'd0, 13'd0, 13'd0, 4'd0, 4'd1, 4'd0, 4'd0);
        do_op("shift", 0, 1, 0, 0);
        load(13'd0, 13'd0, 13'd0, 13'd1, 4'd0, 4'd1, 4'd0, 4'd0);
        do_op("wrap", 8191, 0, 0, 0);
        load(13'd3, 13'd0, 13'd0, 13'd0, 4'b1101, 4'd0, 4'd0, 4'd0);
        do_op("neg5", 8177, 0, 0, 0);
        load(13'd8191, 13'd0, 13'd0, 13'd0, 4'd2, 4'd0, 4'd0, 4'd0);
        do_op("mod", 8190, 0, 0, 0);
        load(13'd2, 13'd0, 13'd0, 13'd0, 4'd3, 4'd4, 4'd0, 4'd0);
        do_op("mul34", 6, 8, 0, 0);
        load(13'd1, 13'd2, 13'd3, 13'd4, 4'd1, 4'd1, 4'd1, 4'd1);
        do_op("full", 8184, 8188, 2, 10);

        // Abort during row 2, with start raised alongside rst.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if (c == 17) chk("abort_row2_s_addr", int'(s_addr), 2);
            @(negedge clk);
        end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_a_addr", int'(a_addr), 0);
        check_res("abort", 0, 0, 0, 0);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1 || busy === 1'b1) dn++;
            @(negedge clk);
        end
        chk("abort_quiet", dn, 0);
        do_op("restart", 8184, 8188, 2, 10);

        // Start pulses while busy must not retrigger.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        dn = 0; first = 0;
        for (int c = 1; c <= 33; c++) begin
            if (done === 1'b1) begin dn++; if (first == 0) first = c; end
            start = (c == 5 || c == 20);
            @(negedge clk);
        end
        start = 1'b0;
        chk("pulse_done_count", dn, 1);
        chk("pulse_done_cycle", first, 33);
        chk("pulse_idle", int'(busy), 0);
        dn = 0;
        for (int c = 0; c < 10; c++) begin
            if (done === 1'b1 || busy === 1'b1) dn++;
            @(negedge clk);
        end
        chk("pulse_no_restart", dn, 0);

        // Start held high: one run per IDLE visit.
        start = 1'b1;
        @(negedge clk);
        dn = 0; first = 0;
        for (int c = 1; c <= 33; c++) begin
            if (done === 1'b1) begin dn++; if (first == 0) first = c; end
            @(negedge clk);
        end
        chk("held_done_count", dn, 1);
        chk("held_done_cycle", first, 33);
        chk("held_idle_visit", int'(busy), 0);
        @(negedge clk);
        chk("held_reaccept", int'(busy), 1);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_second_done", int'(done), 1);
        @(negedge clk);
        check_res("held", 8184, 8188, 2, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
